// File: rtl/a133x_multi_reader_if.sv
// a133x_multi_reader_if: shared SPI bus pins between the reader and the A1339 sensors.
interface a133x_multi_reader_if #(parameter int NUMBER_OF_SENSORS = 4);
  logic sck_o;
  logic [NUMBER_OF_SENSORS-1:0] ss_n_o;
  logic mosi_o;
  logic miso_i;
  modport master(output sck_o, ss_n_o, mosi_o, input miso_i);
  modport slave(input sck_o, ss_n_o, mosi_o, output miso_i);
endinterface

// File: rtl/a133x_multi_reader.sv
// a133x_multi_reader: round-robin CRC-checked SPI poller for A1339 angle sensors.
module a133x_multi_reader #(
  parameter int NUMBER_OF_SENSORS = 4,
  parameter int CLK_DIV = 5,
  parameter int DELAY_CYCLES = 100,
  parameter logic [15:0] CMD = 16'h2000,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic clock,
  input  logic reset_n,
  input  logic enable,
  input  logic [7:0] sensor,
  output logic [11:0] sensor_angle,
  output logic sensor_valid,
  output logic [ERR_CNT_WIDTH-1:0] sensor_crc_errors,
  output logic frame_done,
  output logic [5:0] frame_sensor,
  a133x_multi_reader_if.master spi
);
  function automatic logic [3:0] crc4(input logic [15:0] d);
    logic [3:0] c;
    logic inv;
    c = 4'hF;
    for (int i = 15; i >= 0; i--) begin
      inv = d[i] ^ c[3];
      c = {c[2], c[1], c[0] ^ inv, inv};
    end
    return c;
  endfunction

  localparam logic [19:0] TX = {CMD, crc4(CMD)};
  localparam int CMAX = CLK_DIV > DELAY_CYCLES ? CLK_DIV : DELAY_CYCLES;
  localparam int CW = $clog2(CMAX + 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, CHECK, GAP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [4:0] bit_cnt, bit_n;
  logic ph, ph_n;
  logic [5:0] idx, idx_n;
  logic [19:0] rx;
  logic [11:0] angle [NUMBER_OF_SENSORS];
  logic [ERR_CNT_WIDTH-1:0] err [NUMBER_OF_SENSORS];
  logic [NUMBER_OF_SENSORS-1:0] valid;
  logic half_end, sample, capture, crc_ok, busy;

  assign half_end = cnt == CW'(CLK_DIV - 1);
  assign sample = state == SHIFT && ph && cnt == '0;
  assign capture = state == HOLD && half_end;
  assign crc_ok = crc4(rx[19:4]) == rx[3:0];
  assign busy = state == SETUP || state == SHIFT || state == HOLD;

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      bit_cnt <= '0;
      ph <= 1'b0;
      idx <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      bit_cnt <= bit_n;
      ph <= ph_n;
      idx <= idx_n;
    end

  always_comb begin
    state_n = state;
    cnt_n = cnt + 1'b1;
    bit_n = bit_cnt;
    ph_n = ph;
    idx_n = idx;
    case (state)
      IDLE: begin
        cnt_n = '0;
        state_n = enable ? SETUP : IDLE;
      end
      SETUP: if (half_end) begin
        state_n = SHIFT;
        cnt_n = '0;
        ph_n = 1'b0;
        bit_n = '0;
      end
      SHIFT: if (half_end) begin
        cnt_n = '0;
        ph_n = ~ph;
        if (ph) begin
          state_n = bit_cnt == 5'd19 ? HOLD : SHIFT;
          bit_n = bit_cnt + 5'd1;
        end
      end
      HOLD: if (half_end) begin
        state_n = CHECK;
        cnt_n = '0;
      end
      CHECK: begin
        state_n = GAP;
        cnt_n = '0;
      end
      GAP: if (cnt == CW'(DELAY_CYCLES - 1)) begin
        cnt_n = '0;
        idx_n = idx == 6'(NUMBER_OF_SENSORS - 1) ? 6'd0 : idx + 6'd1;
        state_n = enable ? SETUP : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) rx <= '0;
    else if (sample) rx <= {rx[18:0], spi.miso_i};

  // Results commit on the edge entering CHECK so they appear together with frame_done.
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      valid <= '0;
      for (int i = 0; i < NUMBER_OF_SENSORS; i++) begin
        angle[i] <= '0;
        err[i] <= '0;
      end
    end else if (capture) begin
      for (int i = 0; i < NUMBER_OF_SENSORS; i++)
        if (idx == 6'(i)) begin
          valid[i] <= crc_ok;
          if (crc_ok) angle[i] <= rx[15:4];
          else if (~&err[i]) err[i] <= err[i] + 1'b1;
        end
    end

  always_comb begin
    sensor_angle = '0;
    sensor_valid = 1'b0;
    sensor_crc_errors = '0;
    for (int i = 0; i < NUMBER_OF_SENSORS; i++)
      if (sensor == 8'(i)) begin
        sensor_angle = angle[i];
        sensor_valid = valid[i];
        sensor_crc_errors = err[i];
      end
  end

  assign frame_done = state == CHECK;
  assign frame_sensor = idx;
  assign spi.sck_o = !(state == SHIFT && !ph);
  assign spi.ss_n_o = busy ? ~(NUMBER_OF_SENSORS'(1) << idx) : '1;
  assign spi.mosi_o = state == SETUP ? TX[19] :
                      state == SHIFT ? TX[5'd19 - bit_cnt] :
                      state == HOLD ? TX[0] : 1'b0;
endmodule

// File: tb/tb_a133x_multi_reader.sv
// tb_a133x_multi_reader: directed checks of framing, CRC handling, round-robin and reset behaviour.
module tb_a133x_multi_reader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en_a = 1'b0, en_b = 1'b0;
  logic [7:0] sensor_a = '0, sensor_b = '0;
  logic [11:0] angle_a, angle_b;
  logic valid_a, valid_b, fd_a, fd_b;
  logic [7:0] err_a;
  logic [3:0] err_b;
  logic [5:0] fs_a, fs_b;
  logic sck_a, mosi_a, sck_b, miso_b, idle_b;
  logic [3:0] ss_a;
  logic [2:0] ss_b;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  a133x_multi_reader_if #(.NUMBER_OF_SENSORS(4)) spi_a();
  a133x_multi_reader_if #(.NUMBER_OF_SENSORS(3)) spi_b();

  a133x_multi_reader dut_a (
    .clock(clk), .reset_n(rst_n), .enable(en_a), .sensor(sensor_a),
    .sensor_angle(angle_a), .sensor_valid(valid_a), .sensor_crc_errors(err_a),
    .frame_done(fd_a), .frame_sensor(fs_a), .spi(spi_a.master)
  );

  a133x_multi_reader #(.NUMBER_OF_SENSORS(3), .CLK_DIV(2), .DELAY_CYCLES(4), .ERR_CNT_WIDTH(4)) dut_b (
    .clock(clk), .reset_n(rst_n), .enable(en_b), .sensor(sensor_b),
    .sensor_angle(angle_b), .sensor_valid(valid_b), .sensor_crc_errors(err_b),
    .frame_done(fd_b), .frame_sensor(fs_b), .spi(spi_b.master)
  );

  assign sck_a = spi_a.sck_o;
  assign ss_a = spi_a.ss_n_o;
  assign mosi_a = spi_a.mosi_o;
  assign spi_a.miso_i = 1'b0;
  assign sck_b = spi_b.sck_o;
  assign ss_b = spi_b.ss_n_o;
  assign spi_b.miso_i = miso_b;
  assign idle_b = &ss_b;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // MOSI decode of the first frame on dut_a
  logic [19:0] cap = '0;
  int cap_n = 0;
  always @(posedge sck_a)
    if (!ss_a[0] && cap_n < 20) begin
      cap = {cap[18:0], mosi_a};
      cap_n++;
    end

  // Mode-3 slave model for dut_b: MSB ready at select fall, next bit on each later sck fall
  logic [19:0] resp [3];
  logic [19:0] r;
  int nfall = 0, sel, bi;
  always @(negedge sck_b or posedge idle_b)
    if (idle_b) nfall = 0;
    else nfall++;
  always_comb begin
    sel = !ss_b[0] ? 0 : !ss_b[1] ? 1 : 2;
    bi = nfall == 0 ? 0 : nfall > 20 ? 19 : nfall - 1;
    r = resp[sel];
    miso_b = r[19 - bi];
  end

  // Select monitor for dut_b
  logic [2:0] ss_prev = '1;
  int falls = 0, multi_low = 0, bad_fall = 0;
  int order[$];
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++)
      if (ss_prev[i] && !ss_b[i]) begin
        falls++;
        order.push_back(i);
        if (!sck_b) bad_fall++;
      end
    if ($countones(~ss_b) > 1) multi_low++;
    ss_prev = ss_b;
  end

  task automatic wait_frame(input int s, input string tag);
    int found = 0;
    for (int i = 0; i < 1000 && found == 0; i++) begin
      @(negedge clk);
      if (fd_b && fs_b == 6'(s)) found = 1;
    end
    check(tag, found, 1);
  endtask

  task automatic wait_shift_b(input string tag);
    int found = 0;
    for (int i = 0; i < 400 && found == 0; i++) begin
      @(negedge clk);
      if (!idle_b && !sck_b) found = 1;
    end
    check(tag, found, 1);
  endtask

  initial begin
    int t_f0, t_r0, t_f1, pulses, f0, n0;
    logic [3:0] pa;
    resp[0] = 20'h0000D;
    resp[1] = 20'h0ABC7;
    resp[2] = 20'h00000;
    #1;
    check("rst_sck", sck_a, 1);
    check("rst_ss", ss_a, 4'hF);
    check("rst_mosi", mosi_a, 0);
    check("rst_fd", fd_a, 0);
    check("rst_fs", fs_a, 0);
    check("rst_store", {angle_a, valid_a, err_a}, 0);

    @(negedge clk);
    rst_n = 1'b1;
    en_a = 1'b1;
    t_f0 = -1; t_r0 = -1; t_f1 = -1; pa = '1;
    for (int t = 0; t < 800; t++) begin
      @(negedge clk);
      if (pa[0] && !ss_a[0] && t_f0 < 0) t_f0 = t;
      if (!pa[0] && ss_a[0] && t_r0 < 0) t_r0 = t;
      if (pa[1] && !ss_a[1] && t_f1 < 0) t_f1 = t;
      pa = ss_a;
    end
    en_a = 1'b0;
    check("first_fall", t_f0, 0);
    check("ss0_low_cycles", t_r0 - t_f0, 210);
    check("frame_period", t_f1 - t_f0, 311);
    check("mosi_word", cap, 20'h20009);

    en_b = 1'b1;
    wait_frame(0, "wait_s0");
    check("s0_valid", valid_b, 1);
    sensor_b = 8'd1;
    wait_frame(1, "wait_s1_good");
    check("good_angle", angle_b, 12'hABC);
    check("good_valid", valid_b, 1);
    check("good_err", err_b, 0);
    resp[1] = 20'h0ABC6;
    wait_frame(1, "wait_s1_bad");
    check("bad_angle", angle_b, 12'hABC);
    check("bad_valid", valid_b, 0);
    check("bad_err", err_b, 1);
    sensor_b = 8'd2;
    #1;
    check("s2_err", err_b, 1);
    check("s2_valid", valid_b, 0);
    sensor_b = 8'd1;
    for (int k = 0; k < 16; k++) wait_frame(1, "wait_s1_sat");
    check("sat_err", err_b, 4'hF);
    check("sat_valid", valid_b, 0);
    check("sat_angle", angle_b, 12'hABC);

    check("rr_count", order.size() >= 5, 1);
    for (int k = 0; k < 5; k++)
      check("rr_order", order.size() > k ? order[k] : -1, k % 3);
    check("multi_low", multi_low, 0);
    check("fall_sck_low", bad_fall, 0);

    sensor_b = 8'd3;
    #1;
    check("oor_3", {angle_b, valid_b, err_b}, 0);
    sensor_b = 8'hFF;
    #1;
    check("oor_ff", {angle_b, valid_b, err_b}, 0);

    wait_shift_b("wait_shift1");
    en_b = 1'b0;
    f0 = falls;
    pulses = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (fd_b) pulses++;
    end
    check("drop_pulses", pulses, 1);
    check("drop_no_fall", falls, f0);
    check("drop_idle_ss", ss_b, 3'h7);

    resp[1] = 20'h0ABC7;
    en_b = 1'b1;
    wait_shift_b("wait_shift2");
    #2 rst_n = 1'b0;
    #1;
    check("arst_ss", ss_b, 3'h7);
    check("arst_sck", sck_b, 1);
    sensor_b = 8'd1;
    #1;
    check("arst_store", {angle_b, valid_b, err_b}, 0);
    @(negedge clk);
    n0 = order.size();
    rst_n = 1'b1;
    wait_frame(0, "wait_post_rst");
    check("post_rst_first", order.size() > n0 ? order[n0] : -1, 0);
    check("post_rst_s1", {angle_b, valid_b, err_b}, 0);
    wait_frame(1, "wait_post_rst_s1");
    check("post_rst_s1_angle", angle_b, 12'hABC);
    check("post_rst_s1_valid", valid_b, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/a133x_multi_reader.md
# a133x_multi_reader

Round-robin reader for up to 64 A1339 angle sensors sharing one SPI bus, with an integrated mode-3 SPI shifter. It sends one CRC-protected read command per frame, and checks the CRC on each response. It stores a 12-bit angle, a valid flag and a saturating CRC-error counter per sensor. It sits between the sensor SPI pins and the motor-control logic, which reads results through a `sensor` index mux.

## Interface
- `NUMBER_OF_SENSORS`, 4: sensors on the bus (1..64); one `ss_n_o` line each.
- `CLK_DIV`, 5: `sck_o` half-period in clocks (≥2).
- `DELAY_CYCLES`, 100: idle gap between frames, in clocks (≥1).
- `CMD`, 16'h2000: 16-bit command word sent every frame.
- `ERR_CNT_WIDTH`, 8: width of the per-sensor CRC-error counters.
- `clock  in  1`: system clock.
- `reset_n  in  1`: reset, asynchronous, active-low.
- `enable  in  1`: polling runs while high.
- `sensor  in  8`: read-mux index.
- `sensor_angle  out  12`: stored angle of `sensor`.
- `sensor_valid  out  1`: CRC result of the last completed frame of `sensor`.
- `sensor_crc_errors  out  ERR_CNT_WIDTH`: CRC-error count of `sensor`.
- `frame_done  out  1`: 1-cycle pulse when a frame has been evaluated.
- `frame_sensor  out  6`: index of the sensor just evaluated; valid when `frame_done`=1.
- `sck_o  out  1`: SPI clock, idle high.
- `ss_n_o  out  NUMBER_OF_SENSORS`: active-low chip selects.
- `mosi_o  out  1`: SPI data out.
- `miso_i  in  1`: SPI data in.

## Operation
- **Reset values.**
  - `sck_o`=1, `ss_n_o`=all 1, `mosi_o`=0.
  - All angles, valid flags and error counters are 0.
  - `frame_done`=0, `frame_sensor`=0, current index=0, state=IDLE.
- **Transmit word.** TX word = {CMD, crc4(CMD)}, 20 bits, MSB first.
- **CRC definition.** crc4: bit-serial over 16 bits, MSB first, register C3..C0 initialised to 4'hF. Per bit b:
  - inv = b^C3;
  - C3←C2; C2←C1; C1←C0^inv; C0←inv.
  - Result is {C3,C2,C1,C0}. For CMD 0x2000 the TX word is 20'h20009.
- **SPI mode.** Mode 3. `mosi_o` changes on `sck_o` falling edges; `miso_i` is sampled in the clock cycle `sck_o` rises.
- **States.**
  - IDLE: all selects high. Go to SETUP when `enable`=1.
  - SETUP: `ss_n_o[idx]`=0, `mosi_o`=TX[19], held CLK_DIV cycles.
  - SHIFT: 20 bits. Per bit: `sck_o` low for CLK_DIV cycles (`mosi_o` = current bit), then high for CLK_DIV cycles (sample into RX shift register).
  - HOLD: `sck_o`=1, select still low, held CLK_DIV cycles.
  - CHECK: 1 cycle, selects high.
    - Compare crc4(RX[19:4]) with RX[3:0].
    - Match: angle[idx]←RX[15:4], valid[idx]←1.
    - Mismatch: valid[idx]←0, angle unchanged, err[idx] += 1, saturating at all-ones.
    - `frame_done` pulses this cycle with `frame_sensor`=idx.
  - GAP: DELAY_CYCLES cycles. Then idx←idx+1, wrapping from NUMBER_OF_SENSORS−1 to 0. Next state is SETUP if `enable`=1, else IDLE.
- **Enable deassert mid-frame.** The current frame completes, including CHECK and GAP, then the block enters IDLE.
- **Select lines.** Only `ss_n_o[idx]` may be low, and only in SETUP/SHIFT/HOLD.
- **Out-of-range index.** `sensor` ≥ NUMBER_OF_SENSORS gives angle 0, valid 0, errors 0.
- **Read mux.** The `sensor_*` outputs are combinational from `sensor` and the stored arrays.

## Timing
- Select low: exactly 42·CLK_DIV cycles per frame (SETUP + 40 half-periods + HOLD).
- Frame period: 42·CLK_DIV + 1 + DELAY_CYCLES. With defaults this is 311 cycles.
- A full sweep of all sensors takes NUMBER_OF_SENSORS frame periods.
- First select falls 1 cycle after `enable` is seen high in IDLE.
- Stored results update on the same clock edge at which `frame_done` rises; `sensor_*` reflect them in the same cycle.
- Asynchronous reset mid-frame immediately drives all selects high and `sck_o` high. After reset is released, polling restarts at index 0.

## Test plan
- **Command frame.** Reset, `enable`=1, defaults. The bench decodes MOSI as 20'h20009. `ss_n_o[0]` is low for exactly 210 cycles; the next select falls 311 cycles after the first.
- **Good response.** Slave 1 returns 20'h0ABC7. At the `frame_done` with `frame_sensor`=1: `sensor`=1 reads angle 12'hABC, valid 1, errors 0.
- **Bad CRC.** Slave 1 returns 20'h0ABC6 after the good frame. Angle stays 12'hABC, valid goes 0, errors increments to 1. Repeating 300 times with ERR_CNT_WIDTH=8 gives errors 255, saturated.
- **Round-robin wrap.** With NUMBER_OF_SENSORS=3, the selects assert in order 0,1,2,0,1. Never more than one select is low, and each falls only while `sck_o` is high.
- **Enable drop mid-frame.** Deassert `enable` during SHIFT. The frame completes and `frame_done` pulses once. After GAP no select falls.
- **Reset mid-SHIFT.** Assert reset asynchronously during SHIFT. Selects and `sck_o` go high immediately. After release and `enable`=1, the first frame targets sensor 0, and all stored values read 0 until their frames complete.
